harris_response: RTL
====================

Name: harris_response

Overview:
- Stage directly downstream of the gradient stage.
- Consumes one 4x4 Gx/Gy gradient window per handshake.
- Accumulates the structure tensor (Sxx, Syy, Sxy) with one multiply-accumulate set per cycle, then computes R = det(M) - k*trace(M)^2.
- Emits a saturated signed 32-bit harris_score with a one-cycle valid pulse. This drives the top-level harris_score output.

Parameters:
- GRAD_W, 16: signed gradient element width.
- ACC_W, 40: signed accumulator width for Sxx/Syy/Sxy.
- K_NUM, 5: numerator of k.
- K_SHIFT, 7: k = K_NUM / 2^K_SHIFT (default ≈ 0.039).
- THRESH, 1000: corner threshold; used only with HARRIS_THRESH_EN.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- grad_valid  in  1  Gx/Gy windows valid this cycle.
- Gx  in  16*GRAD_W  flattened 4x4 signed window; element [r][c] at bits [(r*4+c)*GRAD_W +: GRAD_W].
- Gy  in  16*GRAD_W  same layout as Gx.
- in_ready  out  1  block can accept a window.
- harris_score  out  32  signed saturated response.
- score_valid  out  1  one-cycle pulse, harris_score updated.
- overrun  out  1  sticky: a window was dropped.
- corner_flag  out  1  score above THRESH (see Optional Feature).

Behaviour:
- Reset (async assert, sync release) clears the following:
  - state to IDLE;
  - harris_score = 0, score_valid = 0, overrun = 0, corner_flag = 0;
  - accumulators and element index = 0.
- in_ready = 1 only in IDLE.
- FSM states: IDLE, ACCUM, DET, SCORE.
- IDLE: when grad_valid=1, latch Gx/Gy into local registers, clear accumulators and index, go to ACCUM.
- ACCUM: 16 cycles, index 0..15 in row-major order. Each cycle:
  - Sxx += gx*gx, Syy += gy*gy, Sxy += gx*gy;
  - products are full 2*GRAD_W signed and sign-extended to ACC_W.
  - At index 15, go to DET.
- DET: one cycle. Register det = Sxx*Syy - Sxy*Sxy and tr2 = (Sxx+Syy)^2, both at 2*ACC_W signed.
- SCORE: one cycle. Compute:
  - kt = (tr2*K_NUM) >>> K_SHIFT (arithmetic shift, floor);
  - R = det - kt;
  - saturate R to [-2^31, 2^31-1];
  - load harris_score, set score_valid for the next cycle, return to IDLE.
- Timing, with the window accepted at edge T:
  - score_valid = 1 during cycle T+19 only;
  - in_ready = 1 again from cycle T+19;
  - a window presented in T+19 is accepted (back-to-back period 19).
- harris_score holds its value until the next SCORE update.
- grad_valid=1 while in_ready=0:
  - window is ignored and the current computation is unaffected;
  - overrun is set to 1 and stays set until reset.
- Reset asserted mid-operation: computation aborted, no score_valid, all outputs at reset values.
- Gx/Gy inputs only sampled in IDLE. Later input changes do not affect the in-flight result.

Optional Feature:
- Macro HARRIS_THRESH_EN.
- Defined: corner_flag is loaded together with harris_score and equals (R_saturated > THRESH), signed compare. It holds until the next update.
- Undefined: corner_flag tied to 0, no comparator synthesized, THRESH unused.

Decomposition:
- Package harris_pkg:
  - GRAD_W, ACC_W, WIN_N=4, WIN_ELEMS=16;
  - SCORE_MAX=32'h7FFFFFFF, SCORE_MIN=32'h80000000;
  - state enum typedef {IDLE, ACCUM, DET, SCORE}.
- Sub-module structure_tensor_mac:
  - holds the three multipliers and Sxx/Syy/Sxy accumulators;
  - inputs clear/enable/gx/gy;
  - instantiated once.
- FSM, DET/SCORE arithmetic and saturation stay in harris_response.

Test Plan:
- All Gx=Gy=0, one grad_valid -> score_valid exactly 19 cycles later, harris_score=0, in_ready low cycles T+1..T+18.
- Gx=1 everywhere, Gy=0 -> Sxx=16, tr2=256, kt=10, harris_score=-10. Then Gx=Gy=1 everywhere -> harris_score=-40 (back-to-back accept at T+19).
- Gx=1 rows 0-1 else 0, Gy=1 rows 2-3 else 0 -> det=64, kt=10, harris_score=54. With HARRIS_THRESH_EN and THRESH=50, corner_flag=1; with THRESH=1000, corner_flag=0.
- Saturation cases:
  - Gx=1020 rows 0-1, Gy=-1020 rows 2-3 -> harris_score=32'h7FFFFFFF;
  - Gx=Gy=1020 everywhere -> harris_score=32'h80000000.
- grad_valid at T and again at T+5 -> second window dropped, overrun=1 permanently, single score_valid at T+19 with the first window's result.
- reset asserted at T+8 for 2 cycles -> no score_valid, outputs zero, in_ready=1 after release. A new window then completes normally 19 cycles after acceptance.

Source files
------------

// File: rtl/harris_pkg.sv
`timescale 1ns/1ps
// harris_pkg: shared widths, score saturation limits and FSM state type for
// the Harris corner response stage.
package harris_pkg;
  localparam int GRAD_W    = 16;
  localparam int ACC_W     = 40;
  localparam int WIN_N     = 4;
  localparam int WIN_ELEMS = WIN_N * WIN_N;

  localparam logic signed [31:0] SCORE_MAX = 32'sh7FFFFFFF;
  localparam logic signed [31:0] SCORE_MIN = 32'sh80000000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DET,
    SCORE
  } state_t;
endpackage

// File: rtl/structure_tensor_mac.sv
`timescale 1ns/1ps
// structure_tensor_mac: three signed multipliers feeding the Sxx/Syy/Sxy
// accumulators of the structure tensor, one gradient pair per cycle.
// Ports:
//   clk, reset        clock, async active-low reset
//   clear             zero all accumulators (takes priority over enable)
//   enable            accumulate gx*gx, gy*gy, gx*gy this cycle
//   gx, gy            signed gradient element
//   sxx, syy, sxy     signed accumulator values
module structure_tensor_mac #(
  parameter int GRAD_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [GRAD_W-1:0] gx,
  input  logic signed [GRAD_W-1:0] gy,
  output logic signed [ACC_W-1:0]  sxx,
  output logic signed [ACC_W-1:0]  syy,
  output logic signed [ACC_W-1:0]  sxy
);

  logic signed [2*GRAD_W-1:0] p_xx;
  logic signed [2*GRAD_W-1:0] p_yy;
  logic signed [2*GRAD_W-1:0] p_xy;

  assign p_xx = gx * gx;
  assign p_yy = gy * gy;
  assign p_xy = gx * gy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sxx <= '0;
      syy <= '0;
      sxy <= '0;
    end else if (clear) begin
      sxx <= '0;
      syy <= '0;
      sxy <= '0;
    end else if (enable) begin
      sxx <= sxx + ACC_W'(p_xx);
      syy <= syy + ACC_W'(p_yy);
      sxy <= sxy + ACC_W'(p_xy);
    end
  end

endmodule

// File: rtl/harris_response.sv
`timescale 1ns/1ps
// harris_response: consumes one 4x4 Gx/Gy window per handshake, accumulates
// the structure tensor over 16 cycles, then computes
// R = det(M) - k*trace(M)^2 with k = K_NUM / 2^K_SHIFT and emits a saturated
// signed 32-bit score with a one-cycle valid pulse (period 19 cycles).
// Optional feature macro: HARRIS_THRESH_EN (corner_flag = score > THRESH);
// without it corner_flag is tied low.
// Ports:
//   clk, reset     clock, async active-low reset
//   grad_valid     Gx/Gy window offered this cycle
//   Gx, Gy         flattened 4x4 signed windows, element [r][c] at (r*4+c)*GRAD_W
//   in_ready       high only while idle
//   harris_score   saturated response, held until the next update
//   score_valid    one-cycle pulse when harris_score updates
//   overrun        sticky: a window arrived while busy and was dropped
//   corner_flag    score above THRESH (feature build only)
module harris_response
  import harris_pkg::*;
#(
  parameter int GRAD_W  = harris_pkg::GRAD_W,
  parameter int ACC_W   = harris_pkg::ACC_W,
  parameter int K_NUM   = 5,
  parameter int K_SHIFT = 7,
  parameter int THRESH  = 1000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            grad_valid,
  input  logic [WIN_ELEMS*GRAD_W-1:0]     Gx,
  input  logic [WIN_ELEMS*GRAD_W-1:0]     Gy,
  output logic                            in_ready,
  output logic signed [31:0]              harris_score,
  output logic                            score_valid,
  output logic                            overrun,
  output logic                            corner_flag
);

  localparam int PW     = 2 * ACC_W;
  // headroom so tr2*K_NUM cannot wrap before the shift
  localparam int WIDE_W = PW + 8;

  state_t                          state;
  logic [WIN_ELEMS*GRAD_W-1:0]     gx_q;
  logic [WIN_ELEMS*GRAD_W-1:0]     gy_q;
  logic [3:0]                      idx;
  logic signed [PW-1:0]            det_q;
  logic signed [PW-1:0]            tr2_q;

  logic signed [GRAD_W-1:0]        gx_cur;
  logic signed [GRAD_W-1:0]        gy_cur;
  logic signed [ACC_W-1:0]         sxx;
  logic signed [ACC_W-1:0]         syy;
  logic signed [ACC_W-1:0]         sxy;
  logic                            accept;

  logic signed [PW-1:0]            tr_sum;
  logic signed [WIDE_W-1:0]        kt;
  logic signed [WIDE_W-1:0]        r_full;
  logic signed [31:0]              r_sat;

  assign accept   = (state == IDLE) && grad_valid;
  assign in_ready = (state == IDLE);

  assign gx_cur = gx_q[int'(idx)*GRAD_W +: GRAD_W];
  assign gy_cur = gy_q[int'(idx)*GRAD_W +: GRAD_W];

  structure_tensor_mac #(
    .GRAD_W (GRAD_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state == ACCUM),
    .gx     (gx_cur),
    .gy     (gy_cur),
    .sxx    (sxx),
    .syy    (syy),
    .sxy    (sxy)
  );

  assign tr_sum = PW'(sxx) + PW'(syy);

  // >>> on a signed operand floors toward -inf
  assign kt     = (WIDE_W'(tr2_q) * WIDE_W'(K_NUM)) >>> K_SHIFT;
  assign r_full = WIDE_W'(det_q) - kt;

  always_comb begin
    r_sat = r_full[31:0];
    if (r_full > WIDE_W'(SCORE_MAX)) begin
      r_sat = SCORE_MAX;
    end else if (r_full < WIDE_W'(SCORE_MIN)) begin
      r_sat = SCORE_MIN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      gx_q         <= '0;
      gy_q         <= '0;
      idx          <= '0;
      det_q        <= '0;
      tr2_q        <= '0;
      harris_score <= '0;
      score_valid  <= 1'b0;
      overrun      <= 1'b0;
`ifdef HARRIS_THRESH_EN
      corner_flag  <= 1'b0;
`endif
    end else begin
      score_valid <= 1'b0;
      if (grad_valid && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (grad_valid) begin
            gx_q  <= Gx;
            gy_q  <= Gy;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          idx <= idx + 4'd1;
          if (idx == 4'(WIN_ELEMS - 1)) begin
            state <= DET;
          end
        end
        DET: begin
          det_q <= (PW'(sxx) * PW'(syy)) - (PW'(sxy) * PW'(sxy));
          tr2_q <= tr_sum * tr_sum;
          state <= SCORE;
        end
        SCORE: begin
          harris_score <= r_sat;
          score_valid  <= 1'b1;
`ifdef HARRIS_THRESH_EN
          corner_flag  <= (r_sat > 32'(THRESH));
`endif
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef HARRIS_THRESH_EN
  assign corner_flag = 1'b0;
`endif

endmodule
